id_decode_stage: RTL and testbench
==================================

# id_decode_stage

Instruction-decode stage of the 8-bit pipeline, sitting between the IF/ID register and the ID/EX register. It owns:
- the 4×8 general register file and the stack pointer;
- the decoder that produces the control bundle captured by ID/EX;
- a two-word-instruction state machine for LDM;
- load-use hazard detection, which stalls fetch and inserts bubbles.

## Interface
Parameters:
- SP_RESET, 8'hFF, stack pointer value after reset
- NREGS, 4, register-file depth (fixed at 4; the index width is 2)

Ports:
- clk  in  1  clock; all state updates on the rising edge
- rst  in  1  reset, asynchronous, active-high
- if_instr  in  8  instruction word from IF/ID: [7:4] opcode, [3:2] ra, [1:0] rb
- if_valid  in  1  if_instr holds a real word
- ex_flush  in  1  taken branch/jump in EX; discard the word currently in ID
- ex_mem_read  in  1  instruction in EX reads memory (LDD or POP)
- ex_rd  in  2  destination register of the instruction in EX
- wb_reg_write  in  1  register-file write enable from WB
- wb_rd  in  2  WB destination register
- wb_data  in  8  WB write data
- stall  out  1  hold PC and IF/ID this cycle
- id_reg_write, id_mem_read, id_mem_write  out  1 each  control bundle to ID/EX
- id_alu_op  out  4  ALU operation
- id_read_data_a, id_read_data_b  out  8 each  operand values
- id_rs, id_rt  out  2 each  source indices, used for forwarding
- reg_dist  out  2  destination register index
- stack_push, stack_pop, setc, clrc  out  1 each  stack and carry-flag controls
- sp_value  out  8  stack address for the current PUSH or POP

## Operation
**Opcode map** (opcodes C–F are reserved):

| Opcode | Mnemonic | Controls |
|---|---|---|
| 0 | NOP | bubble |
| 1 | MOV | reg_write; dest = ra; src = rb; alu_op = PASS_B |
| 2 | ADD | reg_write; dest = ra; alu_op = opcode |
| 3 | SUB | reg_write; dest = ra; alu_op = opcode |
| 4 | AND | reg_write; dest = ra; alu_op = opcode |
| 5 | OR | reg_write; dest = ra; alu_op = opcode |
| 6 | ra = 00: SETC | setc |
| 6 | ra = 01: CLRC | clrc |
| 6 | ra = 10: NOT rb | reg_write; dest = rb |
| 6 | ra = 11: INC rb | reg_write; dest = rb |
| 7 | PUSH rb | stack_push; mem_write; data_b = R[rb] |
| 8 | POP rb | stack_pop; mem_read; reg_write; dest = rb |
| 9 | LDM rb, imm8 | two-word instruction (see FSM below) |
| A | LDD rb, [ra] | mem_read; reg_write; dest = rb |
| B | STD rb, [ra] | mem_write |
| C–F | reserved | decoded as bubble |

- **Bubble**: every control output is 0, data and index outputs are 0, and no state changes.
- **Register file**:
  - written on the rising edge when wb_reg_write is 1.
  - read combinationally with write-through: if a read index equals wb_rd while wb_reg_write is 1, the read returns wb_data.
- **Stack pointer** (arithmetic is modulo 256):
  - PUSH: sp_value = SP, then SP <= SP − 1.
  - POP: sp_value = SP + 1, then SP <= SP + 1.
  - SP updates only on a cycle where the instruction issues (not stalled, not flushed, if_valid = 1).
- **LDM state machine**, states DECODE and IMM:
  - DECODE, valid LDM, no stall/flush: output a bubble, latch rb into a holding register, go to IMM.
  - IMM, if_valid = 1: the word is the immediate. Output reg_write = 1, reg_dist = latched rb, id_read_data_b = if_instr, alu_op = PASS_B. Go to DECODE.
  - IMM, if_valid = 0: output a bubble and remain in IMM.
- **Load-use hazard**:
  - Applies only in DECODE, for valid instructions that read registers.
  - Condition: ex_mem_read = 1 and ex_rd equals a source the instruction actually reads: ra for opcodes 2–5, A and B; rb for opcodes 1–5, 6 (NOT/INC), 7 and B.
  - Response: stall = 1 and a bubble is output. FSM and SP are unchanged. The same word is presented again on the next cycle.
  - The immediate word in IMM never stalls.
- **Priority**: rst > ex_flush > stall > normal decode.
  - ex_flush forces a bubble, forces stall = 0, returns the FSM to DECODE (abandoning any LDM) and leaves SP unchanged.
- **if_valid = 0 in DECODE**: output a bubble; no state change.

## Timing
- The decode outputs and stall are combinational from the current inputs and state; ID/EX registers them at the next edge.
- Latency: one cycle in ID for single-word instructions; LDM occupies ID for two valid words.
- Register-file writes, SP updates and FSM transitions take effect at the rising edge.
- **Reset**:
  - All registers are 0, SP = SP_RESET, FSM = DECODE, the latched LDM destination is 0.
  - While rst is high, every output is 0 except sp_value, which shows SP_RESET.
- **Reset mid-LDM**: the FSM returns to DECODE immediately and the pending immediate is lost.
- **Simultaneous WB write and ID read of the same register**: the new value is seen in the same cycle.
- **SP wrap**: PUSH at SP = 00 yields sp_value = 00 and SP = FF. POP at SP = FF yields sp_value = 00 and SP = 00.

## Test plan
- **Reset**: assert rst mid-cycle with SP previously 40 → SP = FF, FSM = DECODE, all outputs 0 asynchronously.
- **Write-through**: set R1 = 05, R2 = 03, then ADD R1,R2 (8'h26) while WB writes R2 = 07 → id_read_data_a = 05, id_read_data_b = 07, alu_op = 2, reg_dist = 1, reg_write = 1.
- **LDM**: LDM R3 (8'h93) then 8'hA5 → cycle 1 bubble; cycle 2 reg_write = 1, reg_dist = 3, read_data_b = A5. Insert if_valid = 0 between the two words → IMM state held, output is a bubble.
- **Load-use stall**: ex_mem_read = 1, ex_rd = 2 and ID holds ADD R0,R2 → stall = 1, bubble. Next cycle with ex_mem_read = 0 → ADD issues normally.
- **Stack wrap**: from reset, PUSH ×2 then POP ×3 → sp_value sequence FF, FE, FE, FF, 00; final SP = 00.
- **Flush**: ex_flush during the IMM state → bubble, FSM = DECODE, the next word decoded as an opcode. Flush coinciding with a hazard → stall = 0.

Source files
------------

// File: rtl/id_decode_stage_if.sv
// id_decode_stage_if: groups the IF/ID, EX and WB inputs and the ID/EX control outputs of the decode stage.
// Inputs to decode: if_instr/if_valid (fetched word), ex_flush/ex_mem_read/ex_rd (EX feedback), wb_* (register write).
// Outputs from decode: stall, id_* control bundle and operands, reg_dist, stack/carry controls, sp_value.
interface id_decode_stage_if;
  logic [7:0] if_instr;
  logic       if_valid;
  logic       ex_flush;
  logic       ex_mem_read;
  logic [1:0] ex_rd;
  logic       wb_reg_write;
  logic [1:0] wb_rd;
  logic [7:0] wb_data;

  logic       stall;
  logic       id_reg_write;
  logic       id_mem_read;
  logic       id_mem_write;
  logic [3:0] id_alu_op;
  logic [7:0] id_read_data_a;
  logic [7:0] id_read_data_b;
  logic [1:0] id_rs;
  logic [1:0] id_rt;
  logic [1:0] reg_dist;
  logic       stack_push;
  logic       stack_pop;
  logic       setc;
  logic       clrc;
  logic [7:0] sp_value;

  // Upstream pipeline (IF/ID, EX, WB) drives the decode stage.
  modport master (
    output if_instr, if_valid, ex_flush, ex_mem_read, ex_rd, wb_reg_write, wb_rd, wb_data,
    input  stall, id_reg_write, id_mem_read, id_mem_write, id_alu_op, id_read_data_a,
           id_read_data_b, id_rs, id_rt, reg_dist, stack_push, stack_pop, setc, clrc, sp_value
  );

  // The decode stage itself.
  modport slave (
    input  if_instr, if_valid, ex_flush, ex_mem_read, ex_rd, wb_reg_write, wb_rd, wb_data,
    output stall, id_reg_write, id_mem_read, id_mem_write, id_alu_op, id_read_data_a,
           id_read_data_b, id_rs, id_rt, reg_dist, stack_push, stack_pop, setc, clrc, sp_value
  );
endinterface

// File: rtl/id_decode_stage.sv
// id_decode_stage: instruction decode with 4x8 register file, stack pointer, LDM two-word FSM and load-use stall.
// Ports: clk, rst (async, active-high), dec_if (slave modport of id_decode_stage_if).
// Latency: outputs are combinational from inputs and state; one cycle per word. Stall holds PC/IF/ID on load-use.
module id_decode_stage #(
  parameter logic [7:0]  SP_RESET = 8'hFF,
  parameter int unsigned NREGS    = 4
) (
  input logic              clk,
  input logic              rst,
  id_decode_stage_if.slave dec_if
);

  localparam logic [3:0] OP_MOV  = 4'h1;
  localparam logic [3:0] OP_ADD  = 4'h2;
  localparam logic [3:0] OP_SUB  = 4'h3;
  localparam logic [3:0] OP_AND  = 4'h4;
  localparam logic [3:0] OP_OR   = 4'h5;
  localparam logic [3:0] OP_MISC = 4'h6;
  localparam logic [3:0] OP_PUSH = 4'h7;
  localparam logic [3:0] OP_POP  = 4'h8;
  localparam logic [3:0] OP_LDM  = 4'h9;
  localparam logic [3:0] OP_LDD  = 4'hA;
  localparam logic [3:0] OP_STD  = 4'hB;

  // ALU encoding: arithmetic/logic ops reuse their opcode; PASS_B shares MOV's code.
  // NOT/INC get their own codes so EX can tell them apart; non-ALU instructions carry 0.
  localparam logic [3:0] ALU_NONE   = 4'h0;
  localparam logic [3:0] ALU_PASS_B = 4'h1;
  localparam logic [3:0] ALU_NOT    = 4'h6;
  localparam logic [3:0] ALU_INC    = 4'h7;

  typedef enum logic {
    ST_DECODE = 1'b0,
    ST_IMM    = 1'b1
  } state_e;

  state_e     state_q, state_d;
  logic [7:0] sp_q, sp_d;
  logic [1:0] ldm_rd_q, ldm_rd_d;
  logic [7:0] regs_q [NREGS];

  logic [3:0] opcode;
  logic [1:0] ra, rb;
  logic [7:0] rdata_a, rdata_b;
  logic       reads_a, reads_b, has_operands, hazard;

  logic       stall_o, reg_write_o, mem_read_o, mem_write_o;
  logic [3:0] alu_op_o;
  logic [7:0] read_data_a_o, read_data_b_o, sp_value_o;
  logic [1:0] rs_o, rt_o, reg_dist_o;
  logic       stack_push_o, stack_pop_o, setc_o, clrc_o;

  assign opcode = dec_if.if_instr[7:4];
  assign ra     = dec_if.if_instr[3:2];
  assign rb     = dec_if.if_instr[1:0];

  // Write-through so an instruction sees a value being written back this same cycle.
  assign rdata_a = (dec_if.wb_reg_write && dec_if.wb_rd == ra) ? dec_if.wb_data : regs_q[ra];
  assign rdata_b = (dec_if.wb_reg_write && dec_if.wb_rd == rb) ? dec_if.wb_data : regs_q[rb];

  // Which fields are real sources; only these can create a load-use hazard.
  always_comb begin
    reads_a = 1'b0;
    reads_b = 1'b0;
    case (opcode)
      OP_MOV, OP_PUSH:                 reads_b = 1'b1;
      OP_ADD, OP_SUB, OP_AND, OP_OR,
      OP_STD:                          begin reads_a = 1'b1; reads_b = 1'b1; end
      OP_MISC:                         reads_b = ra[1];
      OP_LDD:                          reads_a = 1'b1;
      default:                         ;
    endcase
  end

  assign hazard = dec_if.ex_mem_read &&
                  ((reads_a && dec_if.ex_rd == ra) || (reads_b && dec_if.ex_rd == rb));

  // Every issued single-word instruction except LDM presents its operand fields.
  assign has_operands = (opcode >= OP_MOV) && (opcode <= OP_STD) && (opcode != OP_LDM);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NREGS; i++) regs_q[i] <= '0;
    end else if (dec_if.wb_reg_write) begin
      regs_q[dec_if.wb_rd] <= dec_if.wb_data;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= ST_DECODE;
      sp_q     <= SP_RESET;
      ldm_rd_q <= '0;
    end else begin
      state_q  <= state_d;
      sp_q     <= sp_d;
      ldm_rd_q <= ldm_rd_d;
    end
  end

  always_comb begin
    state_d       = state_q;
    sp_d          = sp_q;
    ldm_rd_d      = ldm_rd_q;
    stall_o       = 1'b0;
    reg_write_o   = 1'b0;
    mem_read_o    = 1'b0;
    mem_write_o   = 1'b0;
    alu_op_o      = ALU_NONE;
    read_data_a_o = '0;
    read_data_b_o = '0;
    rs_o          = '0;
    rt_o          = '0;
    reg_dist_o    = '0;
    stack_push_o  = 1'b0;
    stack_pop_o   = 1'b0;
    setc_o        = 1'b0;
    clrc_o        = 1'b0;
    // Idle cycles expose the current SP so the stack address is always observable.
    sp_value_o    = sp_q;

    if (rst) begin
      sp_value_o = SP_RESET;
    end else if (dec_if.ex_flush) begin
      // Flush wins over stall and abandons a half-fetched LDM.
      state_d = ST_DECODE;
    end else if (state_q == ST_IMM) begin
      if (dec_if.if_valid) begin
        reg_write_o   = 1'b1;
        reg_dist_o    = ldm_rd_q;
        read_data_b_o = dec_if.if_instr;
        alu_op_o      = ALU_PASS_B;
        state_d       = ST_DECODE;
      end
    end else if (dec_if.if_valid) begin
      if (hazard) begin
        stall_o = 1'b1;
      end else begin
        if (has_operands) begin
          rs_o          = ra;
          rt_o          = rb;
          read_data_a_o = rdata_a;
          read_data_b_o = rdata_b;
        end
        case (opcode)
          OP_MOV: begin
            reg_write_o = 1'b1;
            reg_dist_o  = ra;
            alu_op_o    = ALU_PASS_B;
          end
          OP_ADD, OP_SUB, OP_AND, OP_OR: begin
            reg_write_o = 1'b1;
            reg_dist_o  = ra;
            alu_op_o    = opcode;
          end
          OP_MISC: begin
            case (ra)
              2'b00: setc_o = 1'b1;
              2'b01: clrc_o = 1'b1;
              2'b10: begin reg_write_o = 1'b1; reg_dist_o = rb; alu_op_o = ALU_NOT; end
              default: begin reg_write_o = 1'b1; reg_dist_o = rb; alu_op_o = ALU_INC; end
            endcase
          end
          OP_PUSH: begin
            stack_push_o = 1'b1;
            mem_write_o  = 1'b1;
            sp_d         = sp_q - 8'd1;
          end
          OP_POP: begin
            stack_pop_o = 1'b1;
            mem_read_o  = 1'b1;
            reg_write_o = 1'b1;
            reg_dist_o  = rb;
            sp_value_o  = sp_q + 8'd1;
            sp_d        = sp_q + 8'd1;
          end
          OP_LDM: begin
            ldm_rd_d = rb;
            state_d  = ST_IMM;
          end
          OP_LDD: begin
            mem_read_o  = 1'b1;
            reg_write_o = 1'b1;
            reg_dist_o  = rb;
          end
          OP_STD: mem_write_o = 1'b1;
          default: ;
        endcase
      end
    end
  end

  assign dec_if.stall          = stall_o;
  assign dec_if.id_reg_write   = reg_write_o;
  assign dec_if.id_mem_read    = mem_read_o;
  assign dec_if.id_mem_write   = mem_write_o;
  assign dec_if.id_alu_op      = alu_op_o;
  assign dec_if.id_read_data_a = read_data_a_o;
  assign dec_if.id_read_data_b = read_data_b_o;
  assign dec_if.id_rs          = rs_o;
  assign dec_if.id_rt          = rt_o;
  assign dec_if.reg_dist       = reg_dist_o;
  assign dec_if.stack_push     = stack_push_o;
  assign dec_if.stack_pop      = stack_pop_o;
  assign dec_if.setc           = setc_o;
  assign dec_if.clrc           = clrc_o;
  assign dec_if.sp_value       = sp_value_o;

endmodule

// File: tb/tb_id_decode_stage.sv
// tb_id_decode_stage: directed and randomized checks of id_decode_stage against an instruction-level model.
// The model tracks registers, SP and a pending-LDM flag and predicts every output on each falling edge.
// Directed steps pin the model with literal expectations from hand-worked examples.
module tb_id_decode_stage;

  logic clk;
  logic rst;
  int   n_cmp = 0;
  int   n_bad = 0;

  id_decode_stage_if bus ();

  id_decode_stage #(.SP_RESET(8'hFF), .NREGS(4)) dut (
    .clk    (clk),
    .rst    (rst),
    .dec_if (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic       stall, rw, mr, mw;
    logic [3:0] alu;
    logic [7:0] a, b;
    logic [1:0] rs, rt, rd;
    logic       push, pop, setc, clrc;
    logic [7:0] spv;
  } obs_t;

  // Architectural model state.
  logic [7:0] m_regs [4];
  int         m_sp;
  bit         m_imm;
  logic [1:0] m_imm_rd;

  function automatic logic [7:0] rd_val(input logic [1:0] idx);
    if (bus.wb_reg_write && bus.wb_rd == idx) return bus.wb_data;
    return m_regs[idx];
  endfunction

  always @(negedge clk) begin
    obs_t       e, got;
    logic [3:0] op;
    logic [1:0] ra, rb;
    bit         src_a, src_b;
    got = {bus.stall, bus.id_reg_write, bus.id_mem_read, bus.id_mem_write, bus.id_alu_op,
           bus.id_read_data_a, bus.id_read_data_b, bus.id_rs, bus.id_rt, bus.reg_dist,
           bus.stack_push, bus.stack_pop, bus.setc, bus.clrc, bus.sp_value};
    op = bus.if_instr[7:4];
    ra = bus.if_instr[3:2];
    rb = bus.if_instr[1:0];
    e = '0;
    e.spv = 8'(m_sp);
    if (rst) begin
      e.spv = 8'hFF;
      m_sp = 255;
      m_imm = 0;
      m_imm_rd = 2'd0;
      for (int i = 0; i < 4; i++) m_regs[i] = 8'h00;
    end else begin
      if (bus.ex_flush) begin
        m_imm = 0;
      end else if (m_imm) begin
        if (bus.if_valid) begin
          e.rw = 1; e.rd = m_imm_rd; e.b = bus.if_instr; e.alu = 4'd1;
          m_imm = 0;
        end
      end else if (bus.if_valid) begin
        src_a = (op >= 2 && op <= 5) || op == 10 || op == 11;
        src_b = (op >= 1 && op <= 5) || op == 7 || op == 11 || (op == 6 && ra >= 2);
        if (bus.ex_mem_read && ((src_a && bus.ex_rd == ra) || (src_b && bus.ex_rd == rb))) begin
          e.stall = 1;
        end else begin
          if ((op >= 1 && op <= 8) || op == 10 || op == 11) begin
            e.rs = ra; e.rt = rb; e.a = rd_val(ra); e.b = rd_val(rb);
          end
          case (op)
            1:  begin e.rw = 1; e.rd = ra; e.alu = 4'd1; end
            2, 3, 4, 5: begin e.rw = 1; e.rd = ra; e.alu = op; end
            6: begin
              if (ra == 0) e.setc = 1;
              else if (ra == 1) e.clrc = 1;
              else begin e.rw = 1; e.rd = rb; e.alu = (ra == 2) ? 4'd6 : 4'd7; end
            end
            7:  begin e.push = 1; e.mw = 1; m_sp = (m_sp + 255) % 256; end
            8:  begin
              e.pop = 1; e.mr = 1; e.rw = 1; e.rd = rb;
              m_sp = (m_sp + 1) % 256;
              e.spv = 8'(m_sp);
            end
            9:  begin m_imm = 1; m_imm_rd = rb; end
            10: begin e.mr = 1; e.rw = 1; e.rd = rb; end
            11: e.mw = 1;
            default: ;
          endcase
        end
      end
      if (bus.wb_reg_write) m_regs[bus.wb_rd] = bus.wb_data;
    end
    n_cmp++;
    if (got !== e) begin
      n_bad++;
      $display("FAIL model t=%0t instr=%h got %h expected %h", $time, bus.if_instr, got, e);
    end
  end

  task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic drive(input logic [7:0] instr, input logic vld, input logic fl,
                       input logic exmr, input logic [1:0] exrd,
                       input logic wbw, input logic [1:0] wbrd, input logic [7:0] wbd);
    bus.if_instr     = instr;
    bus.if_valid     = vld;
    bus.ex_flush     = fl;
    bus.ex_mem_read  = exmr;
    bus.ex_rd        = exrd;
    bus.wb_reg_write = wbw;
    bus.wb_rd        = wbrd;
    bus.wb_data      = wbd;
    #2;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    int guard;
    rst = 1'b1;
    drive(8'h26, 1, 0, 0, 0, 0, 0, 0);
    chk("rst_reg_write", {7'd0, bus.id_reg_write}, 8'h00);
    chk("rst_alu_op", {4'd0, bus.id_alu_op}, 8'h00);
    chk("rst_sp_value", bus.sp_value, 8'hFF);
    step();
    step();
    rst = 1'b0;

    // Write-through: R1=05, R2=03, then ADD R1,R2 while WB writes R2=07.
    drive(8'h00, 1, 0, 0, 0, 1, 2'd1, 8'h05); step();
    drive(8'h00, 1, 0, 0, 0, 1, 2'd2, 8'h03); step();
    drive(8'h26, 1, 0, 0, 0, 1, 2'd2, 8'h07);
    chk("wt_data_a", bus.id_read_data_a, 8'h05);
    chk("wt_data_b", bus.id_read_data_b, 8'h07);
    chk("wt_alu_op", {4'd0, bus.id_alu_op}, 8'h02);
    chk("wt_reg_dist", {6'd0, bus.reg_dist}, 8'h01);
    chk("wt_reg_write", {7'd0, bus.id_reg_write}, 8'h01);
    step();

    // LDM R3 with an idle slot before the immediate.
    drive(8'h93, 1, 0, 0, 0, 0, 0, 0);
    chk("ldm1_reg_write", {7'd0, bus.id_reg_write}, 8'h00);
    step();
    drive(8'hA5, 0, 0, 0, 0, 0, 0, 0);
    chk("ldm_gap_reg_write", {7'd0, bus.id_reg_write}, 8'h00);
    step();
    drive(8'hA5, 1, 0, 0, 0, 0, 0, 0);
    chk("ldm2_reg_write", {7'd0, bus.id_reg_write}, 8'h01);
    chk("ldm2_reg_dist", {6'd0, bus.reg_dist}, 8'h03);
    chk("ldm2_data_b", bus.id_read_data_b, 8'hA5);
    step();

    // Load-use stall on ADD R0,R2, then release.
    drive(8'h22, 1, 0, 1, 2'd2, 0, 0, 0);
    chk("lu_stall", {7'd0, bus.stall}, 8'h01);
    chk("lu_bubble", {7'd0, bus.id_reg_write}, 8'h00);
    step();
    drive(8'h22, 1, 0, 0, 2'd2, 0, 0, 0);
    chk("lu_release_stall", {7'd0, bus.stall}, 8'h00);
    chk("lu_release_rw", {7'd0, bus.id_reg_write}, 8'h01);
    chk("lu_release_b", bus.id_read_data_b, 8'h07);
    step();

    // Stack wrap: PUSH x2, POP x3 starting from FF.
    drive(8'h70, 1, 0, 0, 0, 0, 0, 0); chk("sp_push1", bus.sp_value, 8'hFF); step();
    drive(8'h70, 1, 0, 0, 0, 0, 0, 0); chk("sp_push2", bus.sp_value, 8'hFE); step();
    drive(8'h80, 1, 0, 0, 0, 0, 0, 0); chk("sp_pop1", bus.sp_value, 8'hFE); step();
    drive(8'h80, 1, 0, 0, 0, 0, 0, 0); chk("sp_pop2", bus.sp_value, 8'hFF); step();
    drive(8'h80, 1, 0, 0, 0, 0, 0, 0); chk("sp_pop3", bus.sp_value, 8'h00); step();
    drive(8'h00, 1, 0, 0, 0, 0, 0, 0); chk("sp_final", bus.sp_value, 8'h00); step();

    // Flush during IMM, then flush coinciding with a hazard.
    drive(8'h91, 1, 0, 0, 0, 0, 0, 0); step();
    drive(8'h26, 1, 1, 0, 0, 0, 0, 0);
    chk("flush_bubble", {7'd0, bus.id_reg_write}, 8'h00);
    step();
    drive(8'h26, 1, 0, 0, 0, 0, 0, 0);
    chk("flush_next_alu", {4'd0, bus.id_alu_op}, 8'h02);
    step();
    drive(8'h26, 1, 1, 1, 2'd2, 0, 0, 0);
    chk("flush_hazard_stall", {7'd0, bus.stall}, 8'h00);
    step();

    // Randomized traffic checked by the model.
    for (int i = 0; i < 3000; i++) begin
      drive(8'($urandom), ($urandom_range(0, 9) != 0), ($urandom_range(0, 15) == 0),
            ($urandom_range(0, 3) == 0), 2'($urandom), 1'($urandom), 2'($urandom), 8'($urandom));
      step();
    end

    // Bring SP to 40, then reset asynchronously in the middle of an LDM.
    drive(8'h00, 0, 1, 0, 0, 0, 0, 0); step();
    guard = 0;
    while (m_sp != 'h40 && guard < 300) begin
      drive(8'h70, 1, 0, 0, 0, 0, 0, 0); step();
      guard++;
    end
    drive(8'h00, 1, 0, 0, 0, 0, 0, 0);
    chk("pre_rst_sp", bus.sp_value, 8'h40);
    step();
    drive(8'h93, 1, 0, 0, 0, 0, 0, 0); step();
    drive(8'hA5, 1, 0, 0, 0, 0, 0, 0);
    chk("pre_rst_imm_rw", {7'd0, bus.id_reg_write}, 8'h01);
    rst = 1'b1;
    #1;
    chk("async_rst_rw", {7'd0, bus.id_reg_write}, 8'h00);
    chk("async_rst_data_b", bus.id_read_data_b, 8'h00);
    chk("async_rst_sp", bus.sp_value, 8'hFF);
    step();
    rst = 1'b0;
    drive(8'h26, 1, 0, 0, 0, 0, 0, 0);
    chk("post_rst_alu", {4'd0, bus.id_alu_op}, 8'h02);
    chk("post_rst_data_a", bus.id_read_data_a, 8'h00);
    step();
    step();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
